// File: rtl/spi_pkg.sv
// Shared types and constants for the SUMP host-side SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LO,
    BIT_HI,
    BYTE_GAP,
    TURN,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  opcode;
  } sump_cmd_t;

  localparam logic [7:0] OP_RESET       = 8'h00;
  localparam logic [7:0] OP_RUN         = 8'h01;
  localparam logic [7:0] OP_QUERY_ID    = 8'h02;
  localparam logic [7:0] OP_QUERY_META  = 8'h04;
  localparam logic [7:0] OP_QUERY_INPUT = 8'h06;

  localparam int unsigned MAX_RX = 4;

  function automatic logic [2:0] clamp_rx(input logic [2:0] n);
    return (n > 3'(MAX_RX)) ? 3'(MAX_RX) : n;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_host_master_if.sv
// Request/response bus between a host controller and spi_host_master.
interface spi_host_master_if;
  import spi_pkg::*;

  logic        start;
  sump_cmd_t   cmd;
  logic        long_cmd;
  logic [2:0]  rx_count;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic [3:0]  rx_valid;

  modport master (
    output start, cmd, long_cmd, rx_count,
    input  busy, done, rx_data, rx_valid
  );

  modport slave (
    input  start, cmd, long_cmd, rx_count,
    output busy, done, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_master_byte.sv
// One SPI mode-0 byte: half-period timing, MSB-first mosi shift-out and
// synchronized miso shift-in. done_c flags the final BIT_HI cycle.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned CNT_W  = 6
) (
  input  logic       clock,
  input  logic       extReset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done_c,
  output logic [7:0] rx_byte_c
);

  spi_state_e       phase;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic [1:0]       miso_sync;

  assign done_c    = (phase == BIT_HI) && (cnt == '0) && (bit_cnt == 3'd0);
  assign rx_byte_c = {rx_sh[6:0], miso_sync[1]};

  always_ff @(posedge clock) begin
    if (extReset) begin
      phase     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      miso_sync <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      case (phase)
        IDLE: begin
          if (start) begin
            phase   <= BIT_LO;
            cnt     <= CNT_W'(CLKDIV - 1);
            bit_cnt <= 3'd7;
            mosi    <= tx_byte[7];
            tx_sh   <= {tx_byte[6:0], 1'b0};
          end
        end
        BIT_LO: begin
          if (cnt == '0) begin
            phase <= BIT_HI;
            cnt   <= CNT_W'(CLKDIV - 1);
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BIT_HI: begin
          if (cnt == '0) begin
            // miso is taken on the last high cycle, well after the slave's falling-edge update
            rx_sh <= rx_byte_c;
            sclk  <= 1'b0;
            if (bit_cnt == 3'd0) begin
              phase <= IDLE;
              mosi  <= 1'b0;
            end else begin
              phase   <= BIT_LO;
              cnt     <= CNT_W'(CLKDIV - 1);
              bit_cnt <= bit_cnt - 3'd1;
              mosi    <= tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_host_master.sv
// SUMP host-side SPI master: sends opcode (+4 data bytes), waits a turnaround,
// then reads up to four response bytes. BIT_LO here covers a whole byte in flight.
module spi_host_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV     = 4,
  parameter int unsigned GAP        = 8,
  parameter int unsigned TURNAROUND = 64
) (
  input  logic               clock,
  input  logic               extReset,
  spi_host_master_if.slave   host,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam int unsigned CNT_MAX = max3(CLKDIV, GAP, TURNAROUND);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  spi_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       byte_idx;
  logic             rx_phase;
  logic [39:0]      cmd_q;
  logic             long_q;
  logic [2:0]       rx_total;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      rx_data_q;
  logic [3:0]       rx_valid_q;

  logic             byte_start_c;
  logic [7:0]       tx_byte_c;
  logic             byte_done_c;
  logic [7:0]       rx_byte_c;
  logic [2:0]       tx_total_c;
  logic [2:0]       next_idx_c;

  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;

  assign tx_total_c = long_q ? 3'd5 : 3'd1;
  assign next_idx_c = byte_idx + 3'd1;

  // Byte engine launch aligns with the edge that moves this FSM into BIT_LO.
  always_comb begin
    byte_start_c = 1'b0;
    tx_byte_c    = 8'h00;
    if (state == IDLE) begin
      byte_start_c = host.start;
      tx_byte_c    = host.cmd.opcode;
    end else if (((state == BYTE_GAP) || (state == TURN)) && (cnt == '0)) begin
      byte_start_c = 1'b1;
      tx_byte_c    = rx_phase ? 8'h00 : cmd_q[{byte_idx, 3'b000} +: 8];
    end
  end

  spi_master_byte #(
    .CLKDIV (CLKDIV),
    .CNT_W  (CNT_W)
  ) u_byte (
    .clock     (clock),
    .extReset  (extReset),
    .start     (byte_start_c),
    .tx_byte   (tx_byte_c),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .done_c    (byte_done_c),
    .rx_byte_c (rx_byte_c)
  );

  always_ff @(posedge clock) begin
    if (extReset) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_idx   <= '0;
      rx_phase   <= 1'b0;
      cmd_q      <= '0;
      long_q     <= 1'b0;
      rx_total   <= '0;
      cs         <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            cmd_q      <= host.cmd;
            long_q     <= host.long_cmd;
            rx_total   <= clamp_rx(host.rx_count);
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            byte_idx   <= '0;
            rx_phase   <= 1'b0;
            cs         <= 1'b0;
            busy_q     <= 1'b1;
            state      <= BIT_LO;
          end
        end
        BIT_LO: begin
          if (byte_done_c) begin
            if (rx_phase) begin
              rx_data_q[{byte_idx[1:0], 3'b000} +: 8] <= rx_byte_c;
              rx_valid_q[byte_idx[1:0]]               <= 1'b1;
            end
            if (!rx_phase && (next_idx_c < tx_total_c)) begin
              state    <= BYTE_GAP;
              cnt      <= CNT_W'(GAP - 1);
              byte_idx <= next_idx_c;
            end else if (!rx_phase && (rx_total != 3'd0)) begin
              state    <= TURN;
              cnt      <= CNT_W'(TURNAROUND - 1);
              byte_idx <= 3'd0;
              rx_phase <= 1'b1;
            end else if (rx_phase && (next_idx_c < rx_total)) begin
              state    <= BYTE_GAP;
              cnt      <= CNT_W'(GAP - 1);
              byte_idx <= next_idx_c;
            end else begin
              state <= HOLD;
              cnt   <= CNT_W'(CLKDIV - 1);
            end
          end
        end
        BYTE_GAP, TURN: begin
          if (cnt == '0) state <= BIT_LO;
          else           cnt   <= cnt - CNT_W'(1);
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= DONE;
            cs     <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
